// File: rtl/attn_value_matmul_pkg.sv
// Purpose : shared types, width helpers and the shift-and-saturate function
//           used by the attention value matmul stage.
// Contents: state_t       FSM state encoding (IDLE, RUN)
//           clog2_min1()  counter width helper (never returns 0)
//           acc_width()   accumulator width for a given element width and row length
//           ACC_W         accumulator width for the default configuration
//           sat_shift()   arithmetic right shift followed by signed saturation
package attn_value_matmul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DW_DEF   = 16;
  localparam int SEQ_DEF  = 64;
  localparam int HD_DEF   = 64;
  localparam int FRAC_DEF = 14;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Product is 2*dw+1 bits (unsigned P widened by one sign bit); summing seq
  // products needs clog2(seq) more bits, so the sum can never overflow.
  function automatic int acc_width(input int dw, input int seq);
    return 2 * dw + 1 + clog2_min1(seq);
  endfunction

  localparam int ACC_W = acc_width(DW_DEF, SEQ_DEF);

  // Floor shift (>>> on a signed value rounds toward -inf), then clamp to the
  // signed dw-bit range. Carried in 64 bits so any supported ACC_W fits.
  function automatic logic [63:0] sat_shift(input logic signed [63:0] a,
                                            input int frac, input int dw);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = a >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/attn_value_matmul_if.sv
// Purpose : job handshake and flat matrix buses of the value matmul stage.
// Signals : start        job request (sampled by the stage only while idle)
//           probs_flat   P[SEQ_LEN][SEQ_LEN], element (m,n) at (m*SEQ_LEN+n)*DW
//           values_flat  V[SEQ_LEN][HEAD_DIM], element (m,d) at (m*HEAD_DIM+d)*DW
//           busy         job in progress
//           done         one-cycle pulse, out_flat complete
//           out_flat     OUT[SEQ_LEN][HEAD_DIM], element (i,d) at (i*HEAD_DIM+d)*DW
// Modports: master drives the job, slave is the matmul stage.
interface attn_value_matmul_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int HEAD_DIM   = 64
);

  logic                                   start;
  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]  probs_flat;
  logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0] values_flat;
  logic                                   busy;
  logic                                   done;
  logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0] out_flat;

  modport master (
    output start, probs_flat, values_flat,
    input  busy, done, out_flat
  );

  modport slave (
    input  start, probs_flat, values_flat,
    output busy, done, out_flat
  );

endinterface

// File: rtl/attn_value_matmul_mac_sat.sv
// Purpose : single multiply-accumulate lane. Multiplies unsigned P by signed V,
//           accumulates, and presents the saturated, shifted value of
//           (acc + product) so the caller can store it in the same cycle as
//           the last term of a dot product.
// Ports   : clk, rst_n   clock and async active-low reset
//           i_clear      zero the accumulator (job start)
//           i_en         perform one MAC this cycle
//           i_last       this term closes the dot product; acc is cleared after it
//           i_p          P element, unsigned fixed point
//           i_v          V element, signed
//           o_res        sat((acc + product) >>> FRAC_BITS)
module attn_value_matmul_mac_sat
  import attn_value_matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int ACC_BITS   = 39
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic                         i_last,
  input  logic        [DATA_WIDTH-1:0] i_p,
  input  logic signed [DATA_WIDTH-1:0] i_v,
  output logic        [DATA_WIDTH-1:0] o_res
);

  localparam int PW = 2 * DATA_WIDTH + 1;

  logic signed [DATA_WIDTH:0] w_p_ext;
  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_BITS-1:0] w_sum;
  logic signed [ACC_BITS-1:0] r_acc;

  assign w_p_ext = $signed({1'b0, i_p});
  assign w_prod  = PW'(w_p_ext) * PW'(i_v);
  assign w_sum   = r_acc + ACC_BITS'(w_prod);
  assign o_res   = DATA_WIDTH'(sat_shift(64'(w_sum), FRAC_BITS, DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_last ? '0 : w_sum;
    end
  end

endmodule

// File: rtl/attn_value_matmul.sv
// Purpose : attention output stage, OUT[i][d] = sum_j P[i][j]*V[j][d], using one
//           time-multiplexed MAC. Loop order j (innermost), d, i. Inputs are
//           captured at the start edge so the buses may change during a job.
// Ports   : clk     rising-edge clock
//           rst_n   async active-low reset (aborts a job, no done pulse)
//           bus     attn_value_matmul_if slave: start, probs_flat, values_flat,
//                   busy, done, out_flat
//
// state | meaning
// IDLE  | waiting for start; out_flat holds last result; done pulses here
// RUN   | one MAC per cycle, SEQ_LEN*HEAD_DIM*SEQ_LEN cycles per job
module attn_value_matmul
  import attn_value_matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int HEAD_DIM   = 64,
  parameter int FRAC_BITS  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  attn_value_matmul_if.slave bus
);

  localparam int JW     = clog2_min1(SEQ_LEN);
  localparam int DDW    = clog2_min1(HEAD_DIM);
  localparam int ACC_B  = acc_width(DATA_WIDTH, SEQ_LEN);
  localparam int P_BITS = DATA_WIDTH * SEQ_LEN * SEQ_LEN;
  localparam int V_BITS = DATA_WIDTH * SEQ_LEN * HEAD_DIM;

  localparam logic [JW-1:0]  J_LAST = JW'(SEQ_LEN - 1);
  localparam logic [DDW-1:0] D_LAST = DDW'(HEAD_DIM - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [P_BITS-1:0] r_p;
  logic [V_BITS-1:0] r_v;
  logic [V_BITS-1:0] r_out;
  logic [JW-1:0]     r_i;
  logic [JW-1:0]     r_j;
  logic [DDW-1:0]    r_d;
  logic              r_done;

  logic w_accept;
  logic w_run;
  logic w_last_j;
  logic w_final;

  logic        [DATA_WIDTH-1:0] w_p;
  logic signed [DATA_WIDTH-1:0] w_v;
  logic        [DATA_WIDTH-1:0] w_res;
  int                           w_oidx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_final)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept = 1'b0;
    w_run    = 1'b0;
    w_last_j = (r_j == J_LAST);
    w_final  = w_last_j && (r_d == D_LAST) && (r_i == J_LAST);
    case (r_state)
      IDLE:    w_accept = bus.start;
      RUN:     w_run    = 1'b1;
      default: ;
    endcase
  end

  assign w_p    = r_p[(int'(r_i) * SEQ_LEN + int'(r_j)) * DATA_WIDTH +: DATA_WIDTH];
  assign w_v    = $signed(r_v[(int'(r_j) * HEAD_DIM + int'(r_d)) * DATA_WIDTH +: DATA_WIDTH]);
  assign w_oidx = int'(r_i) * HEAD_DIM + int'(r_d);

  attn_value_matmul_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_BITS   (ACC_B)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (w_run),
    .i_last  (w_last_j),
    .i_p     (w_p),
    .i_v     (w_v),
    .o_res   (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_v    <= '0;
      r_out  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_d    <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_p <= bus.probs_flat;
        r_v <= bus.values_flat;
        r_i <= '0;
        r_j <= '0;
        r_d <= '0;
      end else if (w_run) begin
        if (w_last_j) begin
          // Store in the same cycle as the final term; the MAC sees acc+prod.
          r_out[w_oidx * DATA_WIDTH +: DATA_WIDTH] <= w_res;
          r_j <= '0;
          if (r_d == D_LAST) begin
            r_d <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_d <= r_d + 1'b1;
          end
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
      r_done <= w_run && w_final;
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.done     = r_done;
  assign bus.out_flat = r_out;

endmodule

// File: tb/tb_attn_value_matmul.sv
// Directed bench for attn_value_matmul at DW=16, SEQ_LEN=4, HEAD_DIM=2, FRAC=14.
// Expected values are hand-computed constants for each scenario.
module tb_attn_value_matmul;

  localparam int DW = 16;
  localparam int SL = 4;
  localparam int HD = 2;
  localparam int FB = 14;

  logic clk;
  logic rst_n;

  attn_value_matmul_if #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .HEAD_DIM(HD)) bus ();

  attn_value_matmul #(
    .DATA_WIDTH (DW),
    .SEQ_LEN    (SL),
    .HEAD_DIM   (HD),
    .FRAC_BITS  (FB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int p [SL][SL];
  int v [SL][HD];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int out_el(input int i, input int d);
    logic [DW-1:0] e;
    e = bus.out_flat[(i * HD + d) * DW +: DW];
    return int'($signed(e));
  endfunction

  task automatic load_bus();
    for (int m = 0; m < SL; m++)
      for (int n = 0; n < SL; n++)
        bus.probs_flat[(m * SL + n) * DW +: DW] = DW'(p[m][n]);
    for (int m = 0; m < SL; m++)
      for (int d = 0; d < HD; d++)
        bus.values_flat[(m * HD + d) * DW +: DW] = DW'(v[m][d]);
  endtask

  task automatic set_identity();
    for (int m = 0; m < SL; m++)
      for (int n = 0; n < SL; n++) p[m][n] = (m == n) ? 16384 : 0;
    for (int m = 0; m < SL; m++)
      for (int d = 0; d < HD; d++) v[m][d] = 10 * m + d;
    load_bus();
  endtask

  task automatic start_job(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 1);
  endtask

  // Counts edges from the current negedge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_pulse(input string tag);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(bus.done), 0);
  endtask

  task automatic check_ident(input string tag);
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++)
        chk($sformatf("%s_out%0d%0d", tag, i, d), out_el(i, d), 10 * i + d);
  endtask

  initial begin
    int lat;
    int ndone;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.probs_flat  = '0;
    bus.values_flat = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_out_zero", 32'(bus.out_flat == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: identity P
    set_identity();
    start_job("s1");
    for (int m = 0; m < SL; m++)
      for (int d = 0; d < HD; d++) v[m][d] = 999;
    load_bus();  // captured copy must be unaffected
    wait_done(lat);
    chk("s1_latency", lat, 32);
    check_ident("s1");
    check_pulse("s1");

    // 2: uniform 0.25
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) p[m][n] = 4096;
      v[m][0] = 100 * (m + 1);
      v[m][1] = -400;
    end
    load_bus();
    start_job("s2");
    wait_done(lat);
    chk("s2_latency", lat, 32);
    for (int i = 0; i < SL; i++) begin
      chk($sformatf("s2_out%0d0", i), out_el(i, 0), 250);
      chk($sformatf("s2_out%0d1", i), out_el(i, 1), -400);
    end

    // 3: one LSB of P times -1 floors to -1
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) p[m][n] = 0;
      for (int d = 0; d < HD; d++) v[m][d] = -1;
    end
    p[0][0] = 1;
    load_bus();
    start_job("s3");
    wait_done(lat);
    chk("s3_latency", lat, 32);
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++)
        chk($sformatf("s3_out%0d%0d", i, d), out_el(i, d), (i == 0) ? -1 : 0);

    // 4: saturation both ways
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) p[m][n] = 16384;
      for (int d = 0; d < HD; d++) v[m][d] = 32767;
    end
    load_bus();
    start_job("s4a");
    wait_done(lat);
    chk("s4a_latency", lat, 32);
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++)
        chk($sformatf("s4a_out%0d%0d", i, d), out_el(i, d), 32767);
    for (int m = 0; m < SL; m++)
      for (int d = 0; d < HD; d++) v[m][d] = -32768;
    load_bus();
    start_job("s4b");
    wait_done(lat);
    chk("s4b_latency", lat, 32);
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < HD; d++)
        chk($sformatf("s4b_out%0d%0d", i, d), out_el(i, d), -32768);

    // 5a: start pulse mid-job is ignored
    set_identity();
    start_job("s5a");
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = (k == 5);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    chk("s5a_latency", lat, 32);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("s5a_extra_done", ndone, 0);
    chk("s5a_idle_busy", 32'(bus.busy), 0);
    check_ident("s5a");

    // 5b: start held high -> back-to-back jobs
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    wait_done(lat);
    chk("s5b_latency1", lat, 32);
    @(posedge clk);
    @(negedge clk);
    chk("s5b_restart_busy", 32'(bus.busy), 1);
    chk("s5b_restart_done", 32'(bus.done), 0);
    bus.start = 1'b0;
    wait_done(lat);
    chk("s5b_latency2", lat, 32);
    check_pulse("s5b");

    // 6: reset mid-job
    start_job("s6");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", 32'(bus.busy), 0);
    chk("s6_rst_done", 32'(bus.done), 0);
    chk("s6_rst_out_zero", 32'(bus.out_flat == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    start_job("s6b");
    wait_done(lat);
    chk("s6b_latency", lat, 32);
    check_ident("s6b");
    check_pulse("s6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
